// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register file write arbiter.
// Contents: FSM state type, requester ids, the hard-wired zero register
// index, and default geometry for the register file.
package regfile_ctrl_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int unsigned ZERO_REG = 0;

    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned ADDR_W_DEF   = 5;
    localparam int unsigned DATA_W_DEF   = 32;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bundle for two requesters (A: ALU, B: load).
// master: drives valid/addr/data, receives ready.
// slave : receives valid/addr/data, drives ready.
// A requester that sees ready=0 must hold valid/addr/data stable.
interface regfile_write_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter, purely combinational.
// Ports:
//   req        - request vector, bit 0 = A, bit 1 = B
//   last_grant - id of the most recently granted requester (state kept by parent)
//   gnt        - one-hot grant
//   gnt_id     - id of the granted requester (REQ_A when nothing is granted)
module rr_arb2
    import regfile_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    always_comb begin
        gnt    = 2'b00;
        gnt_id = REQ_A;
        unique case (req)
            2'b01: begin
                gnt    = 2'b01;
                gnt_id = REQ_A;
            end
            2'b10: begin
                gnt    = 2'b10;
                gnt_id = REQ_B;
            end
            2'b11: begin
                // Tie: favour whoever did not win last time.
                if (last_grant == REQ_B) begin
                    gnt    = 2'b01;
                    gnt_id = REQ_A;
                end else begin
                    gnt    = 2'b10;
                    gnt_id = REQ_B;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter.
// After reset, sweeps every register to INIT_VALUE (one write per cycle),
// then shares the single write port between requesters A and B with
// round-robin arbitration on ties. Writes to register 0 are accepted but
// dropped. Outputs to the register file are registered (1 cycle latency).
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   wb           - requester bundle (slave side)
//   rf_we/rf_waddr/rf_wdata - register file write port
//   init_done    - high once the init sweep has completed
//   conflict_cnt - saturating count of RUN cycles with both requesters valid
module regfile_write_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned       NUM_REGS   = NUM_REGS_DEF,
    parameter int unsigned       ADDR_W     = ADDR_W_DEF,
    parameter int unsigned       DATA_W     = DATA_W_DEF,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_write_arbiter_if.slave wb,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic                   init_done,
    output logic [CNT_W-1:0]       conflict_cnt
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
    logic                last_grant_q, last_grant_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic                init_done_q, init_done_d;
    logic [CNT_W-1:0]    conflict_cnt_q, conflict_cnt_d;

    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                gnt_id;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    // Requests are masked outside RUN so nothing is accepted during the sweep.
    assign req = (state_q == ST_RUN) ? {wb.b_valid, wb.a_valid} : 2'b00;

    rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt        (gnt),
        .gnt_id     (gnt_id)
    );

    assign wb.a_ready = gnt[0];
    assign wb.b_ready = gnt[1];
    assign sel_addr   = (gnt_id == REQ_B) ? wb.b_addr : wb.a_addr;
    assign sel_data   = (gnt_id == REQ_B) ? wb.b_data : wb.a_data;

    always_comb begin
        state_d        = state_q;
        init_ptr_d     = init_ptr_q;
        last_grant_d   = last_grant_q;
        rf_we_d        = 1'b0;
        rf_waddr_d     = '0;
        rf_wdata_d     = '0;
        // Rises one cycle after RUN is entered, i.e. after the last sweep write.
        init_done_d    = (state_q == ST_RUN);
        conflict_cnt_d = conflict_cnt_q;

        unique case (state_q)
            ST_INIT: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = init_ptr_q;
                rf_wdata_d = INIT_VALUE;
                init_ptr_d = init_ptr_q + ADDR_W'(1);
                if (init_ptr_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (|gnt) begin
                    last_grant_d = gnt_id;
                    // Register 0 is hard-wired: accept the request, drop the write.
                    if (sel_addr != ADDR_W'(ZERO_REG)) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = sel_addr;
                        rf_wdata_d = sel_data;
                    end
                end
                if (wb.a_valid && wb.b_valid && (conflict_cnt_q != '1)) begin
                    conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_INIT;
            init_ptr_q     <= '0;
            last_grant_q   <= REQ_B;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            init_done_q    <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            init_ptr_q     <= init_ptr_d;
            last_grant_q   <= last_grant_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            init_done_q    <= init_done_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign init_done    = init_done_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus pushes expected
// register file writes; a negedge monitor pops and compares each rf_we beat.
module tb_regfile_write_arbiter;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        init_done;
    logic [15:0] conflict_cnt;

    int total;
    int bad;
    wr_t sb[$];

    regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) wb ();

    regfile_write_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .wb           (wb),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .init_done    (init_done),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pop one expected write per rf_we beat; also watch grant exclusivity.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("ready_exclusive", 64'(wb.a_ready && wb.b_ready), 64'd0);
            if (rf_we === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", {27'd0, rf_waddr, rf_wdata}, 64'hdead_0000_0000_0000);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("rf_write", {27'd0, rf_waddr, rf_wdata}, {27'd0, e.addr, e.data});
                end
            end
        end
    end

    task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic push_sweep();
        for (int i = 0; i < 32; i++) push_wr(5'(i), 32'd0);
    endtask

    // Called at posedge+1: hold reset over one edge, then check reset state.
    task automatic pulse_reset();
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
    endtask

    task automatic set_a(input logic v, input logic [4:0] a, input logic [31:0] d);
        wb.a_valid = v;
        wb.a_addr  = a;
        wb.a_data  = d;
    endtask

    task automatic set_b(input logic v, input logic [4:0] a, input logic [31:0] d);
        wb.b_valid = v;
        wb.b_addr  = a;
        wb.b_data  = d;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;
        pulse_reset();
        push_sweep();

        // Full init sweep with requesters idle.
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #2;
            check("init_we", 64'(rf_we), 64'd1);
            check("init_done_low", 64'(init_done), 64'd0);
            check("init_readies", 64'({wb.a_ready, wb.b_ready}), 64'd0);
        end
        @(posedge clk);
        #1;
        check("init_done_rise", 64'(init_done), 64'd1);
        check("post_init_we", 64'(rf_we), 64'd0);

        // Single A write.
        set_a(1'b1, 5'd5, 32'hDEADBEEF);
        #1 check("a_ready_single", 64'(wb.a_ready), 64'd1);
        push_wr(5'd5, 32'hDEADBEEF);
        @(posedge clk);
        #1 set_a(1'b0, 5'd0, 32'd0);

        // B write to register 0: accepted, dropped.
        set_b(1'b1, 5'd0, 32'hFFFFFFFF);
        #1 check("b_ready_r0", 64'(wb.b_ready), 64'd1);
        @(posedge clk);
        #1 set_b(1'b0, 5'd0, 32'd0);
        #1 check("r0_dropped", 64'(rf_we), 64'd0);

        // Tie for 4 cycles on reg 3; last_grant=B so A goes first.
        set_a(1'b1, 5'd3, 32'h11);
        set_b(1'b1, 5'd3, 32'h22);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("tie_a_ready", 64'(wb.a_ready), 64'(i % 2 == 0));
            check("tie_b_ready", 64'(wb.b_ready), 64'(i % 2 == 1));
            if (i % 2 == 0) push_wr(5'd3, 32'h11);
            else            push_wr(5'd3, 32'h22);
            @(posedge clk);
            #1;
        end
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        #1 check("conflict_cnt_4", 64'(conflict_cnt), 64'd4);
        check("last_write_r3", 64'({rf_waddr, rf_wdata}), 64'({5'd3, 32'h22}));

        // Reset at init cycle 10, with requests held high during the sweep.
        @(posedge clk);
        #1;
        pulse_reset();
        push_sweep();
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
        end
        pulse_reset();
        push_sweep();
        set_a(1'b1, 5'd0, 32'h1);
        set_b(1'b1, 5'd0, 32'h2);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #2;
            if (k <= 31) begin
                check("init2_readies", 64'({wb.a_ready, wb.b_ready}), 64'd0);
            end
            if (k == 31) begin
                set_a(1'b0, 5'd0, 32'd0);
                set_b(1'b0, 5'd0, 32'd0);
            end
        end
        @(posedge clk);
        #1;
        check("init2_done", 64'(init_done), 64'd1);
        check("init2_no_conflicts", 64'(conflict_cnt), 64'd0);

        // Tie: A wins (last_grant reset to B); B follows; reset cancels next write.
        set_a(1'b1, 5'd9, 32'h1234);
        set_b(1'b1, 5'd10, 32'h5678);
        #1 check("post_rst_tie_a", 64'(wb.a_ready), 64'd1);
        push_wr(5'd9, 32'h1234);
        @(posedge clk);
        #1 set_a(1'b0, 5'd0, 32'd0);
        #1 check("b_after_a", 64'(wb.b_ready), 64'd1);
        push_wr(5'd10, 32'h5678);
        @(posedge clk);
        #1 set_b(1'b0, 5'd0, 32'd0);
        #1 check("conflict_cnt_1", 64'(conflict_cnt), 64'd1);
        @(negedge clk);
        #1;
        set_a(1'b1, 5'd11, 32'h99);
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        set_a(1'b0, 5'd0, 32'd0);
        #1;
        check("run_rst_we_cancel", 64'(rf_we), 64'd0);
        check("run_rst_waddr", 64'(rf_waddr), 64'd0);
        check("run_rst_init_done", 64'(init_done), 64'd0);
        check("run_rst_cnt", 64'(conflict_cnt), 64'd0);
        push_sweep();
        begin
            int n;
            n = 0;
            while (init_done !== 1'b1 && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("init3_done_in_time", 64'(init_done), 64'd1);
            check("init3_cycles", 64'(n), 64'd33);
        end

        // Saturation: both hammer reg 0 (no writes) for 2^16+5 cycles.
        set_a(1'b1, 5'd0, 32'hA);
        set_b(1'b1, 5'd0, 32'hB);
        repeat (65534) @(posedge clk);
        #1 check("cnt_fffe", 64'(conflict_cnt), 64'hFFFE);
        @(posedge clk);
        #1 check("cnt_ffff", 64'(conflict_cnt), 64'hFFFF);
        repeat (6) @(posedge clk);
        #1 check("cnt_saturated", 64'(conflict_cnt), 64'hFFFF);
        set_a(1'b0, 5'd0, 32'd0);
        set_b(1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;
        check("cnt_hold", 64'(conflict_cnt), 64'hFFFF);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A (ALU/R-type writeback) and B (load/memory writeback).
- After reset, a sequencer clears every register to INIT_VALUE, one write per cycle. Only then is writeback traffic accepted.
- Sits between the writeback stage and the register file write-port inputs (Reg_Write / Write_Register / Write_Data).

Parameters:
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- INIT_VALUE, 0, value written to every register during the init sweep.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- a_valid  in  1  requester A has a write pending.
- a_addr  in  ADDR_W  destination register for A.
- a_data  in  DATA_W  write data for A.
- a_ready  out  1  A's request is accepted this cycle.
- b_valid  in  1  requester B has a write pending.
- b_addr  in  ADDR_W  destination register for B.
- b_data  in  DATA_W  write data for B.
- b_ready  out  1  B's request is accepted this cycle.
- rf_we  out  1  register file write enable (to Reg_Write).
- rf_waddr  out  ADDR_W  register file write address.
- rf_wdata  out  DATA_W  register file write data.
- init_done  out  1  high once the init sweep has completed.
- conflict_cnt  out  CNT_W  number of cycles in which A and B were both valid in RUN.

Behaviour:
- Reset (reset high at a clk edge):
  - State becomes INIT, init_ptr=0, last_grant=B (so A wins the first tie).
  - rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0, conflict_cnt=0.
  - a_ready=0 and b_ready=0 while in reset and in INIT.
- State INIT:
  - Each cycle registers rf_we=1, rf_waddr=init_ptr, rf_wdata=INIT_VALUE, then init_ptr++.
  - When init_ptr==NUM_REGS-1 has been issued, go to RUN; init_done=1 from the next cycle.
  - The sweep takes exactly NUM_REGS cycles. Register 0 is included in it.
- State RUN:
  - Grant is combinational. The ready of the granted requester is high in the same cycle.
  - A transfer occurs when valid&&ready at a clk edge.
  - Only A valid: grant A. Only B valid: grant B. Neither valid: no grant.
  - Both valid: grant the requester other than last_grant (round-robin). Update last_grant on every transfer.
  - Exactly one transfer per cycle, at most.
  - The requester that is not granted sees ready=0 and must hold valid, addr and data stable until accepted.
- Output latency: registered, 1 cycle. A transfer at edge N gives rf_we=1 with its addr/data during cycle N..N+1, so the register file commits it at edge N+1. With no transfer, rf_we=0 on the next cycle.
- Writes to register 0:
  - Accepted (ready asserted, round-robin updates) but dropped: rf_we stays 0.
  - Register 0 therefore holds INIT_VALUE after init.
- Same address from both requesters in one cycle: serialised by round-robin. The later grant's data is the final register value. No merging.
- conflict_cnt increments by 1 on each RUN cycle with a_valid&&b_valid. It saturates at all-ones and never wraps.
- reset during INIT or RUN: immediately returns to INIT with the full reset values above. Any in-flight registered write is cancelled (rf_we=0 in the cycle after the reset edge). The init sweep restarts from 0.
- Never asserts a_ready and b_ready in the same cycle.
- Never asserts rf_we with rf_waddr==0 in RUN.

Decomposition:
- Shared package regfile_ctrl_pkg:
  - state enum {ST_INIT, ST_RUN}.
  - requester id constants REQ_A=0, REQ_B=1.
  - ZERO_REG=0.
  - NUM_REGS, ADDR_W and DATA_W defaults.
- Sub-module rr_arb2: two-requester round-robin arbiter.
  - Inputs: req[1:0], last_grant.
  - Outputs: one-hot gnt[1:0], gnt_id.
  - Purely combinational. The last_grant state stays in the parent.

Test Plan:
- Reset, hold valids low -> rf_we=1 for 32 consecutive cycles with rf_waddr 0..31 and rf_wdata=0. init_done rises on cycle 33. a_ready=b_ready=0 throughout INIT.
- After init, A writes addr 5 = 0xDEADBEEF -> a_ready=1 in the same cycle. Next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
- A and B both valid and held for 4 cycles (A addr 3 = 0x11, B addr 3 = 0x22, reloaded on each accept) -> grants alternate A,B,A,B, conflict_cnt=4, and the last committed write to reg 3 is 0x22.
- B writes addr 0 = 0xFFFFFFFF -> b_ready=1, rf_we stays 0 the following cycle. A then wins the next tie (last_grant=B).
- Pulse reset at init cycle 10, then again 2 cycles after an A accept in RUN -> each time the sweep restarts at rf_waddr=0, init_done=0, conflict_cnt=0, and the pending write output is cancelled.
- Force 2^16+5 conflict cycles (CNT_W=16) -> conflict_cnt holds at 0xFFFF and does not wrap.
